// File: rtl/hid_keycode_assembler.sv
// -----------------------------------------------------------------------------
// hid_keycode_assembler
//
// Assembles 8-byte USB HID boot-protocol keyboard reports, delivered one byte
// at a time, into a two-key keycode bus plus the modifier byte. Only complete,
// well-formed, error-free reports are published. The published outputs change
// in one cycle, so downstream logic never sees a half-updated key set.
//
// Parameters
//    TIMEOUT_CYCLES  idle cycles allowed between bytes of one report before
//                    the partial report is abandoned (must be >= 1)
//
// Ports
//    clk_125MHz     in   system clock, rising edge
//    Reset          in   asynchronous active-high reset
//    byte_valid     in   byte_data holds a report byte
//    byte_data      in   report byte
//    byte_last      in   final byte of the report (qualified by byte_valid)
//    byte_ready     out  block accepts a byte this cycle
//    keycode        out  [7:0] first key, [15:8] second key, 0x00 = none
//    modifiers      out  modifier byte of the last committed report
//    keycode_valid  out  one-cycle pulse per committed report
//    report_error   out  one-cycle pulse per discarded rollover/error report
//    malformed      out  one-cycle pulse per short, long or timed-out report
// -----------------------------------------------------------------------------
module hid_keycode_assembler #(
   parameter int TIMEOUT_CYCLES = 1250000
) (
   input  logic        clk_125MHz,
   input  logic        Reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        byte_last,
   output logic        byte_ready,
   output logic [15:0] keycode,
   output logic [7:0]  modifiers,
   output logic        keycode_valid,
   output logic        report_error,
   output logic        malformed
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Timeout fires on the edge that would take the counter to TIMEOUT_CYCLES.
   localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DROP,
      COMMIT
   } state_t;

   state_t         state_reg, state_next;
   logic [2:0]     idx_reg, idx_next;
   logic [CW-1:0]  idle_cnt_reg, idle_cnt_next;
   logic [7:0]     shadow_mod_reg, shadow_mod_next;
   logic [7:0]     slot0_reg, slot0_next;
   logic [7:0]     slot1_reg, slot1_next;
   logic           err_reg, err_next;
   logic [15:0]    keycode_reg, keycode_next;
   logic [7:0]     modifiers_reg, modifiers_next;
   logic           keycode_valid_reg, keycode_valid_next;
   logic           report_error_reg, report_error_next;
   logic           malformed_reg, malformed_next;
   logic           byte_ready_reg, byte_ready_next;

   logic           accept;
   logic           is_err_code;
   logic           idle_expired;
   logic           clear_shadow;

   assign accept       = byte_valid && byte_ready_reg;
   // 0x01..0x03: ErrorRollOver, POSTFail, ErrorUndefined
   assign is_err_code  = (byte_data >= 8'h01) && (byte_data <= 8'h03);
   assign idle_expired = (idle_cnt_reg == IDLE_LIMIT);

   always_ff @(posedge clk_125MHz or posedge Reset) begin
      if (Reset) begin
         state_reg         <= IDLE;
         idx_reg           <= 3'd0;
         idle_cnt_reg      <= '0;
         shadow_mod_reg    <= 8'h00;
         slot0_reg         <= 8'h00;
         slot1_reg         <= 8'h00;
         err_reg           <= 1'b0;
         keycode_reg       <= 16'h0000;
         modifiers_reg     <= 8'h00;
         keycode_valid_reg <= 1'b0;
         report_error_reg  <= 1'b0;
         malformed_reg     <= 1'b0;
         byte_ready_reg    <= 1'b0;
      end else begin
         state_reg         <= state_next;
         idx_reg           <= idx_next;
         idle_cnt_reg      <= idle_cnt_next;
         shadow_mod_reg    <= shadow_mod_next;
         slot0_reg         <= slot0_next;
         slot1_reg         <= slot1_next;
         err_reg           <= err_next;
         keycode_reg       <= keycode_next;
         modifiers_reg     <= modifiers_next;
         keycode_valid_reg <= keycode_valid_next;
         report_error_reg  <= report_error_next;
         malformed_reg     <= malformed_next;
         byte_ready_reg    <= byte_ready_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      idx_next           = idx_reg;
      idle_cnt_next      = idle_cnt_reg;
      shadow_mod_next    = shadow_mod_reg;
      slot0_next         = slot0_reg;
      slot1_next         = slot1_reg;
      err_next           = err_reg;
      keycode_next       = keycode_reg;
      modifiers_next     = modifiers_reg;
      keycode_valid_next = 1'b0;
      report_error_next  = 1'b0;
      malformed_next     = 1'b0;
      clear_shadow       = 1'b0;

      case (state_reg)
         IDLE: begin
            idle_cnt_next = '0;
            if (accept) begin
               // Index 0 of a new report is the modifier byte.
               shadow_mod_next = byte_data;
               if (byte_last) begin
                  malformed_next = 1'b1;
                  clear_shadow   = 1'b1;
               end else begin
                  state_next = COLLECT;
                  idx_next   = 3'd1;
               end
            end
         end

         COLLECT: begin
            if (accept) begin
               idle_cnt_next = '0;
               // Index 1 is reserved; key bytes live at indices 2..7.
               if (idx_reg >= 3'd2) begin
                  if (is_err_code) begin
                     err_next = 1'b1;
                  end else if (byte_data != 8'h00) begin
                     if (slot0_reg == 8'h00) begin
                        slot0_next = byte_data;
                     end else if ((slot1_reg == 8'h00) && (byte_data != slot0_reg)) begin
                        slot1_next = byte_data;
                     end
                  end
               end
               if (byte_last) begin
                  if (idx_reg == 3'd7) begin
                     state_next = COMMIT;
                  end else begin
                     malformed_next = 1'b1;
                     clear_shadow   = 1'b1;
                     state_next     = IDLE;
                  end
               end else if (idx_reg == 3'd7) begin
                  // Too many bytes: swallow the rest of this report.
                  clear_shadow = 1'b1;
                  state_next   = DROP;
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end else if (idle_expired) begin
               malformed_next = 1'b1;
               clear_shadow   = 1'b1;
               state_next     = IDLE;
            end else begin
               idle_cnt_next = idle_cnt_reg + CW'(1);
            end
         end

         DROP: begin
            if (accept) begin
               idle_cnt_next = '0;
               if (byte_last) begin
                  malformed_next = 1'b1;
                  state_next     = IDLE;
               end
            end else if (idle_expired) begin
               malformed_next = 1'b1;
               clear_shadow   = 1'b1;
               state_next     = IDLE;
            end else begin
               idle_cnt_next = idle_cnt_reg + CW'(1);
            end
         end

         COMMIT: begin
            if (err_reg) begin
               report_error_next = 1'b1;
            end else begin
               keycode_next       = {slot1_reg, slot0_reg};
               modifiers_next     = shadow_mod_reg;
               keycode_valid_next = 1'b1;
            end
            clear_shadow = 1'b1;
            state_next   = IDLE;
         end

         default: begin
            clear_shadow = 1'b1;
            state_next   = IDLE;
         end
      endcase

      // Any exit from a report starts the next one from a clean shadow.
      if (clear_shadow) begin
         idx_next        = 3'd0;
         idle_cnt_next   = '0;
         shadow_mod_next = 8'h00;
         slot0_next      = 8'h00;
         slot1_next      = 8'h00;
         err_next        = 1'b0;
      end

      // Registered ready: low exactly during the COMMIT cycle.
      byte_ready_next = (state_next != COMMIT);
   end

   assign byte_ready    = byte_ready_reg;
   assign keycode       = keycode_reg;
   assign modifiers     = modifiers_reg;
   assign keycode_valid = keycode_valid_reg;
   assign report_error  = report_error_reg;
   assign malformed     = malformed_reg;

endmodule

// File: tb/tb_hid_keycode_assembler.sv
module tb_hid_keycode_assembler;

   localparam time PERIOD = 8;
   localparam int  K_OK  = 0;
   localparam int  K_ERR = 1;
   localparam int  K_MAL = 2;

   typedef logic [7:0] bq_t[$];

   logic        clk_125MHz = 1'b0;
   logic        Reset = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_last = 1'b0;
   logic        byte_ready;
   logic [15:0] keycode;
   logic [7:0]  modifiers;
   logic        keycode_valid;
   logic        report_error;
   logic        malformed;

   int          total = 0;
   int          passed = 0;
   logic [15:0] exp_key = 16'h0000;
   logic [7:0]  exp_mod = 8'h00;
   time         acc_time = 0;
   time         first_time = 0;

   always #(PERIOD/2) clk_125MHz = ~clk_125MHz;

   hid_keycode_assembler #(.TIMEOUT_CYCLES(16)) dut (
      .clk_125MHz    (clk_125MHz),
      .Reset         (Reset),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_last     (byte_last),
      .byte_ready    (byte_ready),
      .keycode       (keycode),
      .modifiers     (modifiers),
      .keycode_valid (keycode_valid),
      .report_error  (report_error),
      .malformed     (malformed)
   );

   // Reference model: outcome of one report sent without stalls.
   function automatic void model(input bq_t q, output int kind,
                                 output logic [15:0] k, output logic [7:0] m);
      logic [7:0] keys[$];
      bit err;
      bit seen;
      k = 16'h0000;
      m = 8'h00;
      if (q.size() != 8) begin
         kind = K_MAL;
         return;
      end
      err = 0;
      for (int i = 2; i < 8; i++)
         if (q[i] >= 8'h01 && q[i] <= 8'h03) err = 1;
      if (err) begin
         kind = K_ERR;
         return;
      end
      for (int i = 2; i < 8; i++) begin
         seen = 0;
         foreach (keys[j]) if (keys[j] == q[i]) seen = 1;
         if (q[i] != 8'h00 && !seen && keys.size() < 2) keys.push_back(q[i]);
      end
      if (keys.size() > 0) k[7:0]  = keys[0];
      if (keys.size() > 1) k[15:8] = keys[1];
      m = q[0];
      kind = K_OK;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input bit last);
      bit done = 0;
      int g = 0;
      byte_valid = 1'b1;
      byte_data  = d;
      byte_last  = last;
      while (!done && g < 50) begin
         if (byte_ready) begin
            @(posedge clk_125MHz);
            acc_time = $time;
            done = 1;
         end
         @(negedge clk_125MHz);
         g++;
      end
      if (!done) begin
         total++;
         $display("FAIL send_byte_ready_timeout got=ready_low want=accept");
      end
   endtask

   task automatic idle_gap(input int n);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      repeat (n) @(negedge clk_125MHz);
   endtask

   task automatic do_report(input bq_t q, input int max_gap, input string name);
      int kind;
      logic [15:0] k;
      logic [7:0]  m;
      logic [27:0] got, want;
      model(q, kind, k, m);
      for (int i = 0; i < q.size(); i++) begin
         send_byte(q[i], i == q.size() - 1);
         if (i == 0) first_time = acc_time;
         if (i != q.size() - 1 && max_gap > 0) idle_gap($urandom_range(0, max_gap));
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      got = {keycode, modifiers, keycode_valid, report_error, malformed, byte_ready};
      if (kind == K_MAL) begin
         want = {exp_key, exp_mod, 3'b001, 1'b1};
         total++;
         if (got !== want) $display("FAIL %s_malformed got=%h want=%h", name, got, want);
         else passed++;
      end else begin
         want = {exp_key, exp_mod, 3'b000, 1'b0};
         total++;
         if (got !== want) $display("FAIL %s_bubble got=%h want=%h", name, got, want);
         else passed++;
         if (kind == K_OK) begin
            exp_key = k;
            exp_mod = m;
         end
         @(negedge clk_125MHz);
         got  = {keycode, modifiers, keycode_valid, report_error, malformed, byte_ready};
         want = {exp_key, exp_mod, kind == K_OK, kind == K_ERR, 1'b0, 1'b1};
         total++;
         if (got !== want) $display("FAIL %s_commit got=%h want=%h", name, got, want);
         else passed++;
      end
      $display("report %s len=%0d kind=%0d keycode=%h modifiers=%h", name, q.size(), kind, keycode, modifiers);
   endtask

   task automatic test_reset();
      logic [27:0] got;
      @(negedge clk_125MHz);
      got = {keycode, modifiers, keycode_valid, report_error, malformed, byte_ready};
      total++;
      if (got !== 28'h0) $display("FAIL reset_state got=%h want=%h", got, 28'h0);
      else passed++;
      Reset = 1'b0;
      #1;
      total++;
      if (byte_ready !== 1'b0) $display("FAIL ready_before_edge got=%b want=0", byte_ready);
      else passed++;
      @(negedge clk_125MHz);
      total++;
      if (byte_ready !== 1'b1) $display("FAIL ready_after_edge got=%b want=1", byte_ready);
      else passed++;
   endtask

   task automatic test_basic();
      do_report('{8'h00, 8'h00, 8'h1A, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, 0, "basic");
   endtask

   task automatic test_error();
      do_report('{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01}, 0, "rollover");
   endtask

   task automatic test_dup();
      do_report('{8'h02, 8'h00, 8'h04, 8'h04, 8'h07, 8'h16, 8'h00, 8'h00}, 2, "dup");
      do_report('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, "zeros");
   endtask

   task automatic test_short_long();
      do_report('{8'h11, 8'h00, 8'h05, 8'h06, 8'h07}, 0, "short");
      do_report('{8'h11}, 0, "single");
      do_report('{8'h00, 8'h00, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F}, 0, "long");
      total++;
      if ((acc_time - first_time) !== 9 * PERIOD)
         $display("FAIL long_accept_span got=%0t want=%0t", acc_time - first_time, 9 * PERIOD);
      else passed++;
   endtask

   task automatic test_timeout();
      int k = 0;
      logic [27:0] got, want;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h1A, 0);
      byte_valid = 1'b0;
      total++;
      if (malformed !== 1'b0) $display("FAIL timeout_early got=%b want=0", malformed);
      else passed++;
      while (k < 40 && malformed !== 1'b1) begin
         @(negedge clk_125MHz);
         k++;
      end
      total++;
      if (k !== 16) $display("FAIL timeout_cycles got=%0d want=16", k);
      else passed++;
      got  = {keycode, modifiers, keycode_valid, report_error, malformed, byte_ready};
      want = {exp_key, exp_mod, 3'b001, 1'b1};
      total++;
      if (got !== want) $display("FAIL timeout_outputs got=%h want=%h", got, want);
      else passed++;
      $display("timeout after %0d idle cycles", k);
      do_report('{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, "after_timeout");
   endtask

   task automatic test_back_to_back();
      time t_end;
      do_report('{8'h01, 8'h00, 8'h2A, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h00}, 0, "b2b_a");
      t_end = acc_time;
      do_report('{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h2A}, 0, "b2b_b");
      total++;
      if ((first_time - t_end) !== 2 * PERIOD)
         $display("FAIL b2b_spacing got=%0t want=%0t", first_time - t_end, 2 * PERIOD);
      else passed++;
   endtask

   task automatic test_reset_midreport();
      logic [27:0] got;
      send_byte(8'h20, 0);
      send_byte(8'h00, 0);
      send_byte(8'h2C, 0);
      send_byte(8'h2D, 0);
      byte_valid = 1'b0;
      Reset = 1'b1;
      #1;
      got = {keycode, modifiers, keycode_valid, report_error, malformed, byte_ready};
      total++;
      if (got !== 28'h0) $display("FAIL reset_mid_async got=%h want=%h", got, 28'h0);
      else passed++;
      exp_key = 16'h0000;
      exp_mod = 8'h00;
      @(negedge clk_125MHz);
      Reset = 1'b0;
      @(negedge clk_125MHz);
      do_report('{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00}, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int r = 0; r < 30; r++) begin
         bq_t q;
         int len;
         int sel;
         int v;
         sel = $urandom_range(0, 9);
         len = (sel == 0) ? 5 : (sel == 1) ? 10 : (sel == 2) ? 1 : 8;
         for (int i = 0; i < len; i++) begin
            if (i < 2) begin
               q.push_back(8'($urandom));
            end else begin
               v = $urandom_range(0, 19);
               if (v < 6)       q.push_back(8'h00);
               else if (v == 6) q.push_back(8'($urandom_range(1, 3)));
               else             q.push_back(8'(4 + $urandom_range(0, 5)));
            end
         end
         do_report(q, 3, $sformatf("rand%0d", r));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_dup();
      test_short_long();
      test_timeout();
      test_back_to_back();
      test_reset_midreport();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #(PERIOD * 20000);
      $display("FAIL global_time_limit got=running want=finished");
      $fatal(1);
   end

endmodule

// File: doc/hid_keycode_assembler.md
# hid_keycode_assembler

Parses 8-byte USB HID boot-protocol keyboard reports arriving as a byte stream from the USB host/MCU bridge. Publishes the 16-bit two-key `keycode` bus consumed by the player-motion and game-control logic (low byte = first pressed key, high byte = second). Filters malformed, error and stalled reports so downstream logic sees only complete, valid key sets, updated atomically.

## Interface
- `TIMEOUT_CYCLES`, default 1250000: max idle cycles between bytes inside a report (10 ms at 125 MHz) before abort.
- `clk_125MHz`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `byte_valid`  in  1  source has a report byte on `byte_data`.
- `byte_data`  in  8  report byte.
- `byte_last`  in  1  marks final byte of a report; qualified by `byte_valid`.
- `byte_ready`  out  1  block can accept a byte; transfer occurs on an edge where `byte_valid && byte_ready`.
- `keycode`  out  16  [7:0] first nonzero key, [15:8] second nonzero key; 0x00 = none.
- `modifiers`  out  8  modifier byte of the last committed report.
- `keycode_valid`  out  1  one-cycle pulse on each commit, including commits with unchanged value.
- `report_error`  out  1  one-cycle pulse when a rollover/error report is discarded.
- `malformed`  out  1  one-cycle pulse when a short, long or timed-out report is discarded.

## Operation
- States: IDLE, COLLECT, DROP, COMMIT. Byte index counter `idx` is 3 bits, 0..7.
- IDLE: first accepted byte is index 0. Enter COLLECT with `idx` = 1, or finalize immediately if `byte_last`.
- COLLECT, per accepted byte at index i:
  - i = 0: store in shadow modifier register.
  - i = 1: reserved; ignore.
  - i = 2..7: if byte in 0x01..0x03 (ErrorRollOver/POSTFail/ErrorUndefined), set sticky err flag.
  - Else if nonzero and shadow slot0 empty: fill slot0.
  - Else if nonzero and slot1 empty and byte ≠ slot0: fill slot1.
  - Further keys and duplicate keys are ignored.
- Finalize on accepted byte:
  - `byte_last` with i = 7: go to COMMIT.
  - `byte_last` with i < 7: short report; pulse `malformed`, go to IDLE.
  - i = 7 without `byte_last`: long report; go to DROP.
- DROP: accept and discard bytes until one with `byte_last`. Then pulse `malformed` and go to IDLE.
- COMMIT lasts one cycle with `byte_ready` = 0.
  - If err: `keycode`/`modifiers` hold their previous values, pulse `report_error`, no `keycode_valid`.
  - Else: load `keycode` = {slot1, slot0} and `modifiers` from shadow, and pulse `keycode_valid`.
  - Clear shadow state; go to IDLE.
- Timeout: in COLLECT or DROP, an idle counter (width ceil(log2(TIMEOUT_CYCLES+1))) increments each cycle with no accepted byte and clears on every acceptance.
  - On reaching TIMEOUT_CYCLES: pulse `malformed`, clear shadow state, go to IDLE. Outputs are unchanged.
- Published `keycode`/`modifiers` change only in COMMIT, never mid-report.

## Timing
- Reset values: `keycode` 0x0000, `modifiers` 0x00, `keycode_valid`/`report_error`/`malformed` 0, `byte_ready` 0, state IDLE, counters 0.
- `byte_ready` is registered. It rises on the first edge after `Reset` deasserts, is 0 only in COMMIT, and otherwise is 1.
- Latency: the final byte is accepted at edge N; `keycode`, `modifiers` and the pulse update at edge N+1; `byte_ready` is back to 1 after edge N+1.
- Back-to-back reports: the first byte of the next report can be accepted at edge N+2 (one bubble per report).
- `malformed` for short/long/timeout asserts the cycle after the terminating accept (or the timeout edge). There is no bubble in that case.
- Reset asserted mid-report: everything clears immediately; the partial report is lost; no pulse is produced.
- Pulses are exclusive: `keycode_valid`, `report_error` and `malformed` are never high together.

## Test plan
- Stream 00 00 1A 07 00 00 00 00 (last on byte 7) → edge after final accept: `keycode` = 0x071A, `modifiers` = 0x00, `keycode_valid` pulses once, `byte_ready` low 1 cycle.
- Report 02 00 04 04 07 16 00 00 → duplicate ignored, third key dropped: `keycode` = 0x0704, `modifiers` = 0x02. Follow with an all-zero report → `keycode` = 0x0000, `keycode_valid` pulses.
- After `keycode` = 0x071A, send 00 00 01 01 01 01 01 01 → `report_error` pulses, `keycode` stays 0x071A.
- Send 5 bytes with `byte_last` on the 5th → `malformed` pulses, outputs unchanged. Send 10 bytes with last on the 10th → all accepted, `malformed` once after the 10th.
- Send 3 bytes then stall TIMEOUT_CYCLES (set to 16 in the bench) → `malformed` at cycle 16. A following valid report 00 00 04 00.. commits `keycode` = 0x0004.
- Assert `Reset` after 4 bytes of a report → all outputs 0 asynchronously. After release, a full valid report commits normally with no stale shadow keys.
